// File: rtl/hyperbus_rst_seq.sv
// Per-PHY HyperBus reset/power-up sequencer with a small register interface.
// Each PHY runs ASSERT -> WAIT -> READY on its own down-counter and can be re-triggered over CTRL.
module hyperbus_rst_seq #(
    parameter int unsigned NumPhys        = 2,
    parameter int unsigned RegAddrWidth   = 32,
    parameter int unsigned RegDataWidth   = 32,
    parameter int unsigned RstPulseCycles = 200,
    parameter int unsigned StartupCycles  = 60000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [RegAddrWidth-1:0] reg_addr_i,
    input  logic                    reg_write_i,
    input  logic [RegDataWidth-1:0] reg_wdata_i,
    input  logic [3:0]              reg_wstrb_i,
    input  logic                    reg_valid_i,
    output logic [RegDataWidth-1:0] reg_rdata_o,
    output logic                    reg_ready_o,
    output logic                    reg_error_o,
    output logic [NumPhys-1:0]      hyper_reset_no,
    output logic [NumPhys-1:0]      phy_ready_o
);

    localparam int unsigned RstLoadInit = (RstPulseCycles == 0) ? 0 : RstPulseCycles - 1;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    logic [31:0]        rst_cycles_q, rst_cycles_d;
    logic [31:0]        startup_cycles_q, startup_cycles_d;
    logic [31:0]        rst_load, startup_load;
    logic [31:0]        wdata;
    logic [31:0]        status;
    logic [31:0]        rdata;
    logic [1:0]         sel;
    logic               addr_err;
    logic               wr_en;
    logic               ctrl_wr;
    logic [NumPhys-1:0] trig;
    logic [NumPhys-1:0] rst_n_q;
    logic [NumPhys-1:0] ready_q;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Address decode: anything past STARTUP_CYCLES or not word aligned is rejected.
    assign wdata    = 32'(reg_wdata_i);
    assign sel      = reg_addr_i[3:2];
    assign addr_err = (reg_addr_i > RegAddrWidth'(32'hC)) || (reg_addr_i[1:0] != 2'b00);
    assign wr_en    = reg_valid_i && reg_write_i && !addr_err;
    assign ctrl_wr  = wr_en && (sel == 2'd0);

    assign rst_load     = (rst_cycles_q == 32'd0) ? 32'd0 : rst_cycles_q - 32'd1;
    assign startup_load = (startup_cycles_q == 32'd0) ? 32'd0 : startup_cycles_q - 32'd1;

    always_comb begin
        rst_cycles_d     = rst_cycles_q;
        startup_cycles_d = startup_cycles_q;
        if (wr_en && (sel == 2'd2)) rst_cycles_d = merge_bytes(rst_cycles_q, wdata, reg_wstrb_i);
        if (wr_en && (sel == 2'd3)) startup_cycles_d = merge_bytes(startup_cycles_q, wdata, reg_wstrb_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cycles_q     <= 32'(RstPulseCycles);
            startup_cycles_q <= 32'(StartupCycles);
        end else begin
            rst_cycles_q     <= rst_cycles_d;
            startup_cycles_q <= startup_cycles_d;
        end
    end

    always_comb begin
        status                 = '0;
        status[NumPhys-1:0]    = ready_q;
        status[16 +: NumPhys]  = ~rst_n_q;
    end

    always_comb begin
        rdata = '0;
        if (reg_valid_i && !reg_write_i && !addr_err) begin
            case (sel)
                2'd1:    rdata = status;
                2'd2:    rdata = rst_cycles_q;
                2'd3:    rdata = startup_cycles_q;
                default: rdata = '0;
            endcase
        end
    end

    assign reg_rdata_o    = RegDataWidth'(rdata);
    assign reg_ready_o    = reg_valid_i;
    assign reg_error_o    = reg_valid_i && addr_err;
    assign hyper_reset_no = rst_n_q;
    assign phy_ready_o    = ready_q;

    for (genvar g = 0; g < NumPhys; g++) begin : g_phy
        state_e      state_q, state_d;
        logic [31:0] cnt_q, cnt_d;

        assign trig[g] = ctrl_wr && wdata[g] && reg_wstrb_i[g/8];

        // Trigger wins over any counter-driven transition.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (trig[g]) begin
                state_d = ST_ASSERT;
                cnt_d   = rst_load;
            end else begin
                case (state_q)
                    ST_ASSERT: begin
                        if (cnt_q == 32'd0) begin
                            state_d = ST_WAIT;
                            cnt_d   = startup_load;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q == 32'd0) state_d = ST_READY;
                        else                cnt_d   = cnt_q - 32'd1;
                    end
                    ST_READY: ;
                    default: begin
                        state_d = ST_ASSERT;
                        cnt_d   = rst_load;
                    end
                endcase
            end
        end

        // Pad and ready flops follow the next state so they change on the same edge.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q    <= ST_ASSERT;
                cnt_q      <= 32'(RstLoadInit);
                rst_n_q[g] <= 1'b0;
                ready_q[g] <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                rst_n_q[g] <= (state_d != ST_ASSERT);
                ready_q[g] <= (state_d == ST_READY);
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_rst_seq.sv
// Directed self-checking bench for hyperbus_rst_seq with R=3, S=5 defaults and two PHYs.
module tb_hyperbus_rst_seq;

    logic        clk;
    logic        rst;
    logic [31:0] reg_addr;
    logic        reg_write;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_valid;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        reg_error;
    logic [1:0]  hyper_reset_n;
    logic [1:0]  phy_ready;

    int tests = 0;
    int fails = 0;

    hyperbus_rst_seq #(
        .NumPhys(2), .RegAddrWidth(32), .RegDataWidth(32),
        .RstPulseCycles(3), .StartupCycles(5)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_addr_i(reg_addr), .reg_write_i(reg_write), .reg_wdata_i(reg_wdata),
        .reg_wstrb_i(reg_wstrb), .reg_valid_i(reg_valid),
        .reg_rdata_o(reg_rdata), .reg_ready_o(reg_ready), .reg_error_o(reg_error),
        .hyper_reset_no(hyper_reset_n), .phy_ready_o(phy_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d,
                            output logic e, output logic rdy);
        reg_addr  = a;
        reg_write = 1'b0;
        reg_valid = 1'b1;
        #1;
        d   = reg_rdata;
        e   = reg_error;
        rdy = reg_ready;
        reg_valid = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        reg_addr  = a;
        reg_write = 1'b1;
        reg_wdata = d;
        reg_wstrb = s;
        reg_valid = 1'b1;
        tick();
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    // Checks default timing after rst_i falls: low through edge 2, high after 3, ready after 8.
    task automatic check_default_release(input string tag);
        logic [1:0] exp_hr, exp_rdy;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_hr  = (k >= 3) ? 2'b11 : 2'b00;
            exp_rdy = (k >= 8) ? 2'b11 : 2'b00;
            tests++;
            if (hyper_reset_n !== exp_hr) begin
                fails++;
                $display("FAIL %s_hr edge %0d: got %b want %b", tag, k, hyper_reset_n, exp_hr);
            end
            tests++;
            if (phy_ready !== exp_rdy) begin
                fails++;
                $display("FAIL %s_ready edge %0d: got %b want %b", tag, k, phy_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, r;
        rst = 1'b1;
        repeat (3) tick();
        tests++;
        if (hyper_reset_n !== 2'b00 || phy_ready !== 2'b00) begin
            fails++;
            $display("FAIL reset_hold: got hr=%b rdy=%b want 00/00", hyper_reset_n, phy_ready);
        end
        rst = 1'b0;
        check_default_release("release");
        read_reg(32'h4, d, e, r);
        tests++;
        if (d !== 32'h0000_0003 || e !== 1'b0 || r !== 1'b1) begin
            fails++;
            $display("FAIL status_ready: got %h err=%b rdy=%b want 00000003/0/1", d, e, r);
        end
        read_reg(32'h8, d, e, r);
        tests++;
        if (d !== 32'd3) begin
            fails++;
            $display("FAIL rst_cycles_default: got %0d want 3", d);
        end
        read_reg(32'hC, d, e, r);
        tests++;
        if (d !== 32'd5) begin
            fails++;
            $display("FAIL startup_default: got %0d want 5", d);
        end
    endtask

    task automatic test_trigger_phy1();
        logic [31:0] d; logic e, r;
        logic [1:0] exp_hr, exp_rdy;
        write_reg(32'h8, 32'd4, 4'hF);
        write_reg(32'h0, 32'h2, 4'hF);
        tests++;
        if (hyper_reset_n !== 2'b01 || phy_ready !== 2'b01) begin
            fails++;
            $display("FAIL trig1_entry: got hr=%b rdy=%b want 01/01", hyper_reset_n, phy_ready);
        end
        read_reg(32'h4, d, e, r);
        tests++;
        if (d !== 32'h0002_0001) begin
            fails++;
            $display("FAIL trig1_status: got %h want 00020001", d);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_hr  = {(k >= 4), 1'b1};
            exp_rdy = {(k >= 9), 1'b1};
            tests++;
            if (hyper_reset_n !== exp_hr || phy_ready !== exp_rdy) begin
                fails++;
                $display("FAIL trig1_seq edge +%0d: got hr=%b rdy=%b want %b/%b",
                         k, hyper_reset_n, phy_ready, exp_hr, exp_rdy);
            end
        end
    endtask

    task automatic test_retrigger();
        write_reg(32'h0, 32'h1, 4'h1);
        tick();
        write_reg(32'h0, 32'h1, 4'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (hyper_reset_n[0] !== (k >= 4)) begin
                fails++;
                $display("FAIL retrig_assert edge +%0d: got %b want %b", k, hyper_reset_n[0], (k >= 4));
            end
        end
        // PHY0 is now two cycles into WAIT.
        write_reg(32'h0, 32'h1, 4'h1);
        tests++;
        if (hyper_reset_n !== 2'b10 || phy_ready !== 2'b10) begin
            fails++;
            $display("FAIL retrig_wait: got hr=%b rdy=%b want 10/10", hyper_reset_n, phy_ready);
        end
        repeat (9) tick();
        tests++;
        if (hyper_reset_n !== 2'b11 || phy_ready !== 2'b11) begin
            fails++;
            $display("FAIL retrig_done: got hr=%b rdy=%b want 11/11", hyper_reset_n, phy_ready);
        end
    endtask

    task automatic test_zero_counts();
        write_reg(32'h8, 32'd0, 4'hF);
        write_reg(32'hC, 32'd0, 4'hF);
        write_reg(32'h0, 32'h3, 4'h1);
        tests++;
        if (hyper_reset_n !== 2'b00 || phy_ready !== 2'b00) begin
            fails++;
            $display("FAIL zero_entry: got hr=%b rdy=%b want 00/00", hyper_reset_n, phy_ready);
        end
        tick();
        tests++;
        if (hyper_reset_n !== 2'b11 || phy_ready !== 2'b00) begin
            fails++;
            $display("FAIL zero_release: got hr=%b rdy=%b want 11/00", hyper_reset_n, phy_ready);
        end
        tick();
        tests++;
        if (hyper_reset_n !== 2'b11 || phy_ready !== 2'b11) begin
            fails++;
            $display("FAIL zero_ready: got hr=%b rdy=%b want 11/11", hyper_reset_n, phy_ready);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e, r;
        read_reg(32'h10, d, e, r);
        tests++;
        if (e !== 1'b1 || d !== 32'h0 || r !== 1'b1) begin
            fails++;
            $display("FAIL err_0x10: got err=%b rdata=%h rdy=%b want 1/0/1", e, d, r);
        end
        read_reg(32'h6, d, e, r);
        tests++;
        if (e !== 1'b1 || d !== 32'h0) begin
            fails++;
            $display("FAIL err_0x6: got err=%b rdata=%h want 1/0", e, d);
        end
        write_reg(32'h10, 32'hFFFF_FFFF, 4'hF);
        write_reg(32'h6, 32'h3, 4'hF);
        write_reg(32'h1, 32'h3, 4'hF);
        write_reg(32'hA, 32'd7, 4'hF);
        write_reg(32'h0, 32'h3, 4'h0);
        write_reg(32'h0, 32'h3, 4'h2);
        tick();
        tests++;
        if (hyper_reset_n !== 2'b11 || phy_ready !== 2'b11) begin
            fails++;
            $display("FAIL err_no_trigger: got hr=%b rdy=%b want 11/11", hyper_reset_n, phy_ready);
        end
        read_reg(32'h8, d, e, r);
        tests++;
        if (d !== 32'h0 || e !== 1'b0) begin
            fails++;
            $display("FAIL err_no_write: got rst_cycles=%h err=%b want 0/0", d, e);
        end
        write_reg(32'h8, 32'h1234_5678, 4'b0101);
        read_reg(32'h8, d, e, r);
        tests++;
        if (d !== 32'h0034_0078) begin
            fails++;
            $display("FAIL wstrb_merge: got %h want 00340078", d);
        end
        write_reg(32'h4, 32'hFFFF_FFFF, 4'hF);
        read_reg(32'h4, d, e, r);
        tests++;
        if (d !== 32'h0000_0003 || e !== 1'b0) begin
            fails++;
            $display("FAIL status_ro: got %h err=%b want 00000003/0", d, e);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic e, r;
        write_reg(32'h8, 32'd2, 4'hF);
        write_reg(32'hC, 32'd6, 4'hF);
        write_reg(32'h0, 32'h3, 4'h1);
        repeat (4) tick();
        tests++;
        if (hyper_reset_n !== 2'b11 || phy_ready !== 2'b00) begin
            fails++;
            $display("FAIL async_pre: got hr=%b rdy=%b want 11/00", hyper_reset_n, phy_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (hyper_reset_n !== 2'b00 || phy_ready !== 2'b00) begin
            fails++;
            $display("FAIL async_assert: got hr=%b rdy=%b want 00/00", hyper_reset_n, phy_ready);
        end
        tick();
        rst = 1'b0;
        check_default_release("async_release");
        read_reg(32'h8, d, e, r);
        tests++;
        if (d !== 32'd3) begin
            fails++;
            $display("FAIL async_rst_cycles: got %0d want 3", d);
        end
        read_reg(32'hC, d, e, r);
        tests++;
        if (d !== 32'd5) begin
            fails++;
            $display("FAIL async_startup: got %0d want 5", d);
        end
    endtask

    initial begin
        rst       = 1'b1;
        reg_addr  = '0;
        reg_write = 1'b0;
        reg_wdata = '0;
        reg_wstrb = '0;
        reg_valid = 1'b0;
        test_reset();
        test_trigger_phy1();
        test_retrigger();
        test_zero_counts();
        test_errors();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hyperbus_rst_seq.md
# hyperbus_rst_seq

Per-PHY HyperBus reset and power-up sequencer, register-programmable, generalising the single fixed startup delay of the HyperBus wrapper to `NumPhys` independent channels. It sits beside the HyperBus controller in the system clock domain and has three jobs: drive each PHY's `hyper_reset_no` pad, time the device startup window, and flag each channel ready to upstream logic. Each PHY can also be reset again at runtime from software over the register bus.

## Interface
- `NumPhys`, 2: number of independent HyperBus PHY channels; legal range 1..16.
- `RegAddrWidth`, 32: register bus address width.
- `RegDataWidth`, 32: register bus data width; must be 32.
- `RstPulseCycles`, 200: reset value of RST_CYCLES.
- `StartupCycles`, 60000: reset value of STARTUP_CYCLES.

- `clk_i`  in  1  single clock of the block.
- `rst_i`  in  1  asynchronous, active-high reset.
- `reg_addr_i`  in  RegAddrWidth  register byte address.
- `reg_write_i`  in  1  1 = write, 0 = read.
- `reg_wdata_i`  in  32  write data.
- `reg_wstrb_i`  in  4  byte write strobes.
- `reg_valid_i`  in  1  request valid.
- `reg_rdata_o`  out  32  read data.
- `reg_ready_o`  out  1  response ready.
- `reg_error_o`  out  1  access error.
- `hyper_reset_no`  out  NumPhys  active-low device reset per PHY; registered.
- `phy_ready_o`  out  NumPhys  PHY `i` is out of reset and its startup window has elapsed; registered.

## Operation
Register map. Word-aligned byte offsets:
- 0x0 CTRL, write-1-to-trigger. Bit `i` < NumPhys restarts the sequence of PHY `i`. Reads return 0.
- 0x4 STATUS, read-only. Bits [NumPhys-1:0] = `phy_ready_o`; bits [16+NumPhys-1:16] = per-PHY in-ASSERT flags. Writes are ignored and return no error.
- 0x8 RST_CYCLES, RW, 32 bit. Resets to RstPulseCycles.
- 0xC STARTUP_CYCLES, RW, 32 bit. Resets to StartupCycles.
- RW registers honour `reg_wstrb_i` per byte. For CTRL, only bytes with their strobe set can trigger.
- Error: address > 0xC or `addr[1:0]` != 0 gives `reg_error_o` = 1, `reg_rdata_o` = 0, and no side effect.

Per-PHY FSM. Each PHY has its own FSM and its own 32-bit down-counter `cnt`.
- ASSERT: `hyper_reset_no[i]` = 0, `phy_ready_o[i]` = 0. When `cnt` == 0, go to WAIT and load `cnt` = max(STARTUP_CYCLES,1)-1. Otherwise decrement `cnt`.
- WAIT: `hyper_reset_no[i]` = 1, `phy_ready_o[i]` = 0. When `cnt` == 0, go to READY. Otherwise decrement `cnt`.
- READY: `hyper_reset_no[i]` = 1, `phy_ready_o[i]` = 1. Hold until a trigger.
- Trigger: a CTRL write with bit `i` set, from any state. Go to ASSERT and load `cnt` = max(RST_CYCLES,1)-1. A trigger takes priority over the counter transition in the same cycle.
- Counts are sampled at entry to each state. Writing RST_CYCLES or STARTUP_CYCLES mid-sequence affects only later state entries.
- A value of 0 in either count register behaves as 1.
- Triggers on several PHYs in one write act independently and simultaneously.

## Timing
- While `rst_i` is high, and asynchronously on its assertion:
  - every FSM is in ASSERT, with `cnt` = max(RstPulseCycles,1)-1;
  - `hyper_reset_no` = all 0 and `phy_ready_o` = all 0;
  - RST_CYCLES and STARTUP_CYCLES hold their reset values.
- Reset release: with R = max(RST_CYCLES,1) and S = max(STARTUP_CYCLES,1):
  - `hyper_reset_no[i]` rises after the R-th rising edge following reset release;
  - `phy_ready_o[i]` rises S edges after that.
- Outputs are driven directly by flops, with no combinational path from `reg_*`.
- Register access: single cycle. `reg_ready_o` = `reg_valid_i` combinationally, and `reg_rdata_o` / `reg_error_o` are valid in the same cycle. A write takes effect at the rising edge where `reg_valid_i` && `reg_write_i` is high.
- Trigger latency: CTRL write at edge N gives `hyper_reset_no[i]` = 0 and `phy_ready_o[i]` = 0 after edge N. With the current R, `hyper_reset_no[i]` returns high after edge N+R.
- Re-trigger during ASSERT reloads `cnt`, so the pulse is extended to R cycles from the new trigger.
- Re-trigger during WAIT returns the PHY to ASSERT immediately.
- Asserting `rst_i` mid-sequence returns all PHYs to ASSERT with the parameter defaults.
- STATUS read in the same cycle as a trigger write returns the pre-edge state.

## Test plan
- Reset release, defaults overridden to R=3, S=5 via parameters → `hyper_reset_no` = 0 for edges 1–2 and high after edge 3; `phy_ready_o` high after edge 8; STATUS reads 0x0000_0003 (NumPhys=2).
- Write RST_CYCLES=4, then CTRL=0x2 with PHY1 in READY → PHY1 reset low for exactly 4 cycles and not ready for 4+S cycles; PHY0 stays ready throughout; STATUS shows bit 17 set during the pulse.
- Re-trigger PHY0 two cycles into a 4-cycle pulse → total low time of 6 cycles; re-trigger during WAIT → reset goes low the next cycle.
- RST_CYCLES=0 and STARTUP_CYCLES=0, then trigger → 1-cycle low pulse, with ready 1 cycle after release.
- Access to address 0x10, to 0x6, and a CTRL write with `wstrb`=0 → first two give `error`=1, `rdata`=0, and no state change; the strobe-less write triggers nothing.
- Assert `rst_i` asynchronously mid-WAIT → outputs go to 0 without a clock edge; after release the parameter-default timing resumes.
